// File: rtl/ram_bist_ctrl_pkg.sv
// Shared types for the March C- BIST controller: FSM states, March elements
// and the per-element direction / read-expected / write-value table.
package ram_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CHK,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        M0,
        M1,
        M2,
        M3,
        M4,
        M5
    } elem_e;

    // rd_one / wr_one select the inverted background for that element
    typedef struct packed {
        logic up;
        logic rd_one;
        logic wr_one;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(elem_e e);
        elem_cfg_t c;
        case (e)
            M0:      c = '{up: 1'b1, rd_one: 1'b0, wr_one: 1'b0};
            M1:      c = '{up: 1'b1, rd_one: 1'b0, wr_one: 1'b1};
            M2:      c = '{up: 1'b1, rd_one: 1'b1, wr_one: 1'b0};
            M3:      c = '{up: 1'b0, rd_one: 1'b0, wr_one: 1'b1};
            M4:      c = '{up: 1'b0, rd_one: 1'b1, wr_one: 1'b0};
            default: c = '{up: 1'b0, rd_one: 1'b0, wr_one: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// Simple dual-port RAM access bundle: one write port and one read port
// whose data returns one cycle after the read enable.
interface ram_bist_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_enb;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_enb;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/ram_bist_ctrl_cmp.sv
// Registered read-data comparator: counts miscompares, captures the first
// failing address/word and latches the pass flag when the run finishes.
module ram_bist_ctrl_cmp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ERR_W      = ADDR_WIDTH + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  chk_i,
    input  logic                  fin_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] exp_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [ERR_W-1:0]      err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic                  pass_o
);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    logic [ERR_W-1:0]      err_q, err_d;
    logic [ADDR_WIDTH-1:0] fa_q, fa_d;
    logic [DATA_WIDTH-1:0] fd_q, fd_d;
    logic                  pass_q, pass_d;
    logic                  miss;

    assign miss = chk_i && (rd_data_i != exp_i);

    always_comb begin
        err_d  = err_q;
        fa_d   = fa_q;
        fd_d   = fd_q;
        pass_d = pass_q;
        if (clr_i) begin
            err_d  = '0;
            fa_d   = '0;
            fd_d   = '0;
            pass_d = 1'b0;
        end else if (miss) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) begin
                fa_d = addr_i;
                fd_d = rd_data_i;
            end
        end
        // the final compare lands on the same edge, so judge the updated count
        if (fin_i) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            fa_q   <= '0;
            fd_q   <= '0;
            pass_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            fa_q   <= fa_d;
            fd_q   <= fd_d;
            pass_q <= pass_d;
        end
    end

    assign err_count_o = err_q;
    assign fail_addr_o = fa_q;
    assign fail_data_o = fd_q;
    assign pass_o      = pass_q;
endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller: sweeps the RAM with M0..M5, one access per cycle,
// and hands each returned read word to the comparator one cycle later.
module ram_bist_ctrl
    import ram_bist_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] BG         = '0,
    parameter int                    ERR_W      = ADDR_WIDTH + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [ERR_W-1:0]      err_count_o,
    ram_bist_ctrl_if.master       ram
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    elem_e                 elem_q, elem_d, elem_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_step;
    logic                  at_end;

    logic                  busy_q, busy_d, done_q, done_d;
    logic                  wr_enb_q, wr_enb_d, rd_enb_q, rd_enb_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  chk_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] chk_addr_q;

    assign at_end    = elem_cfg(elem_q).up ? (addr_q == ADDR_MAX) : (addr_q == '0);
    assign addr_step = elem_cfg(elem_q).up ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
    assign elem_nxt  = (elem_q == M5) ? M5 : elem_e'(elem_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            elem_q     <= M0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_enb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_enb_q   <= 1'b0;
            rd_addr_q  <= '0;
            chk_q      <= 1'b0;
            exp_q      <= '0;
            chk_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_enb_q   <= wr_enb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_enb_q   <= rd_enb_d;
            rd_addr_q  <= rd_addr_d;
            // read data returns next cycle, so the expectation travels with it
            chk_q      <= (state_q == ST_RD);
            exp_q      <= elem_cfg(elem_q).rd_one ? ~BG : BG;
            chk_addr_q <= addr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WR;
                    elem_d  = M0;
                    addr_d  = '0;
                end
            end
            ST_WR: begin
                if (at_end) begin
                    state_d = ST_RD;
                    elem_d  = elem_nxt;
                    addr_d  = elem_cfg(elem_nxt).up ? '0 : ADDR_MAX;
                end else begin
                    state_d = (elem_q == M0) ? ST_WR : ST_RD;
                    addr_d  = addr_step;
                end
            end
            ST_RD: begin
                if (elem_q != M5) begin
                    state_d = ST_WR;
                end else if (at_end) begin
                    state_d = ST_CHK;
                end else begin
                    addr_d = addr_step;
                end
            end
            ST_CHK:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs are decoded from the next state so they register alongside it
    always_comb begin
        busy_d    = (state_d == ST_WR) || (state_d == ST_RD) || (state_d == ST_CHK);
        done_d    = (state_d == ST_DONE);
        wr_enb_d  = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        rd_enb_d  = 1'b0;
        rd_addr_d = '0;
        if (state_d == ST_WR) begin
            wr_enb_d  = 1'b1;
            wr_addr_d = addr_d;
            wr_data_d = elem_cfg(elem_d).wr_one ? ~BG : BG;
        end
        if (state_d == ST_RD) begin
            rd_enb_d  = 1'b1;
            rd_addr_d = addr_d;
        end
    end

    ram_bist_ctrl_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ERR_W      (ERR_W)
    ) u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       ((state_q == ST_IDLE) && start_i),
        .chk_i       (chk_q),
        .fin_i       (state_q == ST_CHK),
        .addr_i      (chk_addr_q),
        .exp_i       (exp_q),
        .rd_data_i   (ram.rd_data),
        .err_count_o (err_count_o),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o),
        .pass_o      (pass_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ram.wr_enb  = wr_enb_q;
    assign ram.wr_addr = wr_addr_q;
    assign ram.wr_data = wr_data_q;
    assign ram.rd_enb  = rd_enb_q;
    assign ram.rd_addr = rd_addr_q;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with a stuck-at fault on one bit,
// fixed fault table, random faults against a March C- reference, reset and restart cases.
module tb_ram_bist_ctrl;
    localparam int             DW    = 8;
    localparam int             AW    = 4;
    localparam int             DEPTH = 16;
    localparam int             ERRW  = AW + 3;
    localparam int             BUSY_CYC = 10 * DEPTH + 1;
    localparam logic [DW-1:0]  BG    = 8'h00;

    typedef logic [AW+DW:0] tr_t;

    typedef struct {
        bit            f_en;
        logic [AW-1:0] fa;
        int            fb;
        bit            fv;
        int            e_err;
        logic [AW-1:0] e_fa;
        logic [DW-1:0] e_fd;
        bit            e_pass;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_i;
    logic            busy_o, done_o, pass_o;
    logic [AW-1:0]   fail_addr_o;
    logic [DW-1:0]   fail_data_o;
    logic [ERRW-1:0] err_count_o;

    int checks = 0;
    int errors = 0;
    int viol;
    tr_t exp_tr[$];
    tr_t act_tr[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    ram_bist_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rif();

    ram_bist_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BG         (BG),
        .ERR_W      (ERRW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o),
        .err_count_o (err_count_o),
        .ram         (rif)
    );

    // RAM with latency-1 read; the fault forces one bit of words read from f_addr
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q, rd_word;
    logic [AW-1:0] rd_a_q;
    bit            f_en;
    logic [AW-1:0] f_addr;
    int            f_bit;
    bit            f_val;

    always @(posedge clk) begin
        if (rif.wr_enb) mem[rif.wr_addr] <= rif.wr_data;
        if (rif.rd_enb) begin
            rd_q   <= mem[rif.rd_addr];
            rd_a_q <= rif.rd_addr;
        end
    end

    always_comb begin
        rd_word = rd_q;
        if (f_en && rd_a_q == f_addr) rd_word[f_bit] = f_val;
        rif.rd_data = rd_word;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // March C- as an operation list over a plain array, with the same fault applied on read
    task automatic model(output int errs, output logic [AW-1:0] fa, output logic [DW-1:0] fd);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] v, expw, wv;
        int a;
        errs = 0; fa = '0; fd = '0;
        exp_tr.delete();
        for (int e = 0; e < 6; e++) begin
            expw = (e == 2 || e == 4) ? ~BG : BG;
            wv   = (e == 1 || e == 3) ? ~BG : BG;
            for (int k = 0; k < DEPTH; k++) begin
                a = (e < 3) ? k : DEPTH - 1 - k;
                if (e > 0) begin
                    exp_tr.push_back({1'b0, AW'(a), 8'h00});
                    v = m[a];
                    if (f_en && AW'(a) == f_addr) v[f_bit] = f_val;
                    if (v !== expw) begin
                        if (errs == 0) begin fa = AW'(a); fd = v; end
                        errs++;
                    end
                end
                if (e < 5) begin
                    m[a] = wv;
                    exp_tr.push_back({1'b1, AW'(a), wv});
                end
            end
        end
    endtask

    // from the current negedge, follow the run until done (bounded)
    task automatic wait_run(output int cyc, output bit seen);
        cyc = 0; seen = 0; viol = 0;
        act_tr.delete();
        for (int c = 0; c < 400; c++) begin
            if (done_o) begin seen = 1; break; end
            if (rif.wr_enb && rif.rd_enb) viol++;
            if (!rif.wr_enb && (rif.wr_addr != 0 || rif.wr_data != 0)) viol++;
            if (!rif.rd_enb && rif.rd_addr != 0) viol++;
            if (busy_o) cyc++;
            if (rif.wr_enb) act_tr.push_back({1'b1, rif.wr_addr, rif.wr_data});
            else if (rif.rd_enb) act_tr.push_back({1'b0, rif.rd_addr, 8'h00});
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string name, input int cyc, input bit seen, input int e_err,
                             input logic [AW-1:0] e_fa, input logic [DW-1:0] e_fd, input bit e_pass);
        int mism = 0;
        chk({name, ".done_seen"}, 32'(seen), 1);
        chk({name, ".busy_at_done"}, 32'(busy_o), 0);
        chk({name, ".busy_cycles"}, cyc, BUSY_CYC);
        chk({name, ".err_count"}, 32'(err_count_o), e_err);
        chk({name, ".fail_addr"}, 32'(fail_addr_o), 32'(e_fa));
        chk({name, ".fail_data"}, 32'(fail_data_o), 32'(e_fd));
        chk({name, ".pass"}, 32'(pass_o), 32'(e_pass));
        chk({name, ".exclusive_zero"}, viol, 0);
        chk({name, ".trace_len"}, act_tr.size(), exp_tr.size());
        for (int i = 0; i < act_tr.size() && i < exp_tr.size(); i++)
            if (act_tr[i] !== exp_tr[i]) mism++;
        chk({name, ".trace"}, mism, 0);
        $display("run %s: busy=%0d err=%0d fail_addr=%0d fail_data=%02h pass=%0b",
                 name, cyc, err_count_o, fail_addr_o, fail_data_o, pass_o);
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".status"}, {busy_o, done_o, pass_o, fail_addr_o, fail_data_o, err_count_o}, 0);
        chk({name, ".ports"}, {rif.wr_enb, rif.wr_addr, rif.wr_data, rif.rd_enb, rif.rd_addr}, 0);
    endtask

    initial begin
        int cyc, m_err, bad;
        bit seen;
        logic [AW-1:0] m_fa;
        logic [DW-1:0] m_fd;

        vecs[0] = '{0, 4'd0,  0, 0, 0, 4'd0,  8'h00, 1};
        vecs[1] = '{1, 4'd5,  0, 1, 3, 4'd5,  8'h01, 0};
        vecs[2] = '{1, 4'd9,  7, 0, 2, 4'd9,  8'h7F, 0};
        vecs[3] = '{1, 4'd0,  3, 1, 3, 4'd0,  8'h08, 0};
        vecs[4] = '{1, 4'd15, 0, 0, 2, 4'd15, 8'hFE, 0};

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rd_q = '0; rd_a_q = '0;
        f_en = 0; f_addr = '0; f_bit = 0; f_val = 0;
        rst_n = 1'b0; start_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            f_en = vecs[v].f_en; f_addr = vecs[v].fa; f_bit = vecs[v].fb; f_val = vecs[v].fv;
            model(m_err, m_fa, m_fd);
            start_pulse();
            wait_run(cyc, seen);
            check_run($sformatf("vec%0d", v), cyc, seen, vecs[v].e_err, vecs[v].e_fa,
                      vecs[v].e_fd, vecs[v].e_pass);
            @(negedge clk);
        end

        for (int r = 0; r < 6; r++) begin
            f_en   = ($urandom_range(0, 3) != 0);
            f_addr = AW'($urandom_range(0, DEPTH - 1));
            f_bit  = $urandom_range(0, DW - 1);
            f_val  = $urandom_range(0, 1);
            model(m_err, m_fa, m_fd);
            start_pulse();
            wait_run(cyc, seen);
            check_run($sformatf("rand%0d", r), cyc, seen, m_err, m_fa, m_fd, m_err == 0);
            @(negedge clk);
        end

        // reset in the middle of a run
        f_en = 0;
        start_pulse();
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_o || busy_o) bad++;
        end
        chk("post_reset_quiet", bad, 0);
        model(m_err, m_fa, m_fd);
        start_pulse();
        wait_run(cyc, seen);
        check_run("after_reset", cyc, seen, m_err, m_fa, m_fd, 1);
        @(negedge clk);

        // start held high: one run, then a restart right after done
        f_en = 1; f_addr = 4'd5; f_bit = 0; f_val = 1;
        model(m_err, m_fa, m_fd);
        start_i = 1'b1;
        @(negedge clk);
        wait_run(cyc, seen);
        check_run("hold_first", cyc, seen, m_err, m_fa, m_fd, 0);
        f_en = 0;
        @(negedge clk);
        chk("hold_idle_gap.busy", 32'(busy_o), 0);
        @(negedge clk);
        chk("hold_restart.busy", 32'(busy_o), 1);
        chk("hold_restart.cleared", {err_count_o, fail_addr_o, fail_data_o}, 0);
        start_i = 1'b0;
        model(m_err, m_fa, m_fd);
        wait_run(cyc, seen);
        check_run("hold_second", cyc, seen, m_err, m_fa, m_fd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
